jenc_frame_ctrl: RTL and testbench
==================================

Name: jenc_frame_ctrl

Overview:
- Frame-level sequencer for the JPEG encoder pipeline.
- Accepts a per-frame start request and validates and latches the image size for the encoder.
- Gates the pixel-source handshake into the encoder and monitors the compressed output stream to count bytes and detect end of frame.
- Reports done, error and size; handles abort and stall timeout by flushing the encoder.

Parameters:
SENSOR_X_SIZE, 1280, max image width; size port width XW = $clog2(SENSOR_X_SIZE)
SENSOR_Y_SIZE, 720, max image height; YW = $clog2(SENSOR_Y_SIZE)
TIMEOUT_W, 24, width of stall counter; timeout after 2^TIMEOUT_W-1 idle cycles
FLUSH_CYCLES, 4, cycles enc_flush is held

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start_req  in  1  request to encode one frame (level; sampled in IDLE)
abort  in  1  abort current frame
cfg_x_size_m1  in  XW  requested width-1
cfg_y_size_m1  in  YW  requested height-1
x_size_m1  out  XW  latched width-1 to encoder
y_size_m1  out  YW  latched height-1 to encoder
frame_start  out  1  one-cycle pulse to pixel source when RUN entered
src_valid  in  1  pixel source valid
src_tlast  in  1  last input beat of frame
src_hold  out  1  hold to pixel source
enc_di_valid  out  1  gated valid to encoder
enc_di_hold  in  1  encoder hold
mon_valid  in  1  encoder output valid (tap)
mon_hold  in  1  downstream hold on encoder output (tap)
mon_bytes  in  5  bytes in output beat, 0..16
mon_tlast  in  1  last output beat
enc_flush  out  1  synchronous flush to encoder pipeline
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at frame end (success or error)
error  out  2  0 ok, 1 bad config, 2 abort, 3 timeout; held until next CHECK
size  out  20  compressed byte count, held until next CHECK

Behaviour:
- Reset: state IDLE; x/y_size_m1=0, frame_start=0, enc_flush=0, busy=0, done=0, error=0, size=0, stall counter=0. Gate closed, so src_hold=1 and enc_di_valid=0.
- Gate: enc_di_valid = src_valid & gate_open; src_hold = enc_di_hold | ~gate_open. gate_open only in RUN. Combinational; zero latency.
- Input transfer: src_valid & ~src_hold. Output transfer: mon_valid & ~mon_hold.
- IDLE: start_req=1 → latch cfg sizes into x/y_size_m1 → CHECK.
- CHECK (1 cycle): clear size and error.
  - Bad config if x_size_m1[0]=0, y_size_m1[0]=0, x_size_m1<15, or y_size_m1<15: error=1, done pulse, → IDLE.
  - Otherwise: frame_start pulse, → RUN.
- RUN: input transfer with src_tlast → DRAIN, gate closed next cycle. Output transfer with mon_tlast in RUN is a protocol error → FLUSH, error=2.
- DRAIN: output transfer with mon_tlast → DONE.
- Byte count: size += mon_bytes on every output transfer in RUN/DRAIN, including the tlast beat. Saturates at 20'hFFFFF.
- DONE (1 cycle): done=1, error stays 0 → IDLE. size is final when done is high.
- Stall counter: runs only in RUN/DRAIN. Clears on any input or output transfer, else increments. Reaching all-ones → FLUSH, error=3.
- abort in RUN/DRAIN → FLUSH, error=2.
  - abort has priority over tlast and timeout in the same cycle.
  - abort in IDLE/CHECK/DONE is ignored.
- FLUSH: enc_flush=1 for exactly FLUSH_CYCLES cycles, gate closed. Then done pulse on the cycle after enc_flush falls → IDLE. size keeps its count at flush entry.
- start_req held high re-triggers a frame right after IDLE is re-entered (one IDLE cycle minimum).
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronous).

Test Plan:
- cfg 15x15 (16x16 image), 8 input beats, last with tlast; 3 output beats of 16,16,5 bytes, last with tlast → frame_start once, done 1 cycle after last output, size=37, error=0.
- cfg_x_size_m1=16 → done pulse 1 cycle after CHECK, error=1, frame_start never asserted, src_hold stays 1.
- enc_di_hold=1 for 10 cycles in RUN with src_valid=1 → src_hold=1, enc_di_valid=1, no beat counted, stall counter clears only on transfers.
- abort asserted 5 cycles into RUN, in the same cycle as src_tlast → FLUSH, enc_flush high exactly 4 cycles, then done, error=2.
- TIMEOUT_W=4, no transfers after RUN entry → FLUSH entered 15 cycles later, error=3.
- 70000 output beats of 16 bytes → size saturates at 1048575 and does not wrap.

Source files
------------

// File: rtl/jenc_frame_ctrl.sv
// jenc_frame_ctrl -- frame-level sequencer for the JPEG encoder pipeline.
//
// Takes a per-frame start request, validates and latches the image size, and
// opens the pixel-source -> encoder handshake only while a frame is running.
// It watches the encoder output tap to count compressed bytes and to find the
// end of frame. Abort, a protocol error (output tlast before input tlast) and a
// stall timeout all flush the encoder and end the frame with an error code.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   start_req            frame request (level, sampled in IDLE)
//   abort                abort the running frame (RUN/DRAIN only)
//   cfg_x/y_size_m1      requested width-1 / height-1
//   x/y_size_m1          latched width-1 / height-1 to the encoder
//   frame_start          one-cycle pulse to the pixel source for a good frame
//   src_valid/src_tlast  pixel source beat / last beat
//   src_hold             hold back to the pixel source
//   enc_di_valid         gated valid to the encoder
//   enc_di_hold          encoder input hold
//   mon_valid/mon_hold   encoder output tap handshake
//   mon_bytes/mon_tlast  bytes in output beat (0..16) / last output beat
//   enc_flush            synchronous flush to the encoder pipeline
//   busy, done           not idle / one-cycle end-of-frame pulse
//   error                0 ok, 1 bad config, 2 abort/protocol, 3 timeout
//   size                 compressed byte count (saturating)
module jenc_frame_ctrl #(
    parameter  int SENSOR_X_SIZE = 1280,
    parameter  int SENSOR_Y_SIZE = 720,
    parameter  int TIMEOUT_W     = 24,
    parameter  int FLUSH_CYCLES  = 4,
    localparam int XW            = $clog2(SENSOR_X_SIZE),
    localparam int YW            = $clog2(SENSOR_Y_SIZE)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start_req,
    input  logic          abort,
    input  logic [XW-1:0] cfg_x_size_m1,
    input  logic [YW-1:0] cfg_y_size_m1,
    output logic [XW-1:0] x_size_m1,
    output logic [YW-1:0] y_size_m1,
    output logic          frame_start,
    input  logic          src_valid,
    input  logic          src_tlast,
    output logic          src_hold,
    output logic          enc_di_valid,
    input  logic          enc_di_hold,
    input  logic          mon_valid,
    input  logic          mon_hold,
    input  logic [4:0]    mon_bytes,
    input  logic          mon_tlast,
    output logic          enc_flush,
    output logic          busy,
    output logic          done,
    output logic [1:0]    error,
    output logic [19:0]   size
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);
    // One below all-ones: the counter reaches all-ones on the same edge that
    // moves the FSM to FLUSH.
    localparam logic [TIMEOUT_W-1:0] STALL_LAST = ~TIMEOUT_W'(1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_CFG     = 2'd1;
    localparam logic [1:0] ERR_ABORT   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_RUN, ST_DRAIN, ST_DONE, ST_FLUSH
    } state_t;

    state_t               state, nxt_state;
    logic                 gate_open;
    logic                 in_xfer, out_xfer;
    logic                 cfg_ok, active, timeout;
    logic                 err_ld;
    logic [1:0]           err_val;
    logic [TIMEOUT_W-1:0] stall_cnt;
    logic [FCW-1:0]       flush_cnt;
    logic [20:0]          size_sum;

    // Handshake gate: purely combinational, zero latency.
    assign enc_di_valid = src_valid & gate_open;
    assign src_hold     = enc_di_hold | ~gate_open;

    assign in_xfer  = src_valid & ~src_hold;
    assign out_xfer = mon_valid & ~mon_hold;
    assign active   = (state == ST_RUN) || (state == ST_DRAIN);

    // Encoder needs odd size_m1 (even dimensions) of at least 16 pixels.
    assign cfg_ok = x_size_m1[0] & y_size_m1[0] &
                    (x_size_m1 >= XW'(15)) & (y_size_m1 >= YW'(15));

    assign timeout  = ~in_xfer & ~out_xfer & (stall_cnt == STALL_LAST);
    assign size_sum = {1'b0, size} + 21'(mon_bytes);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= nxt_state;
    end

    // ---------------- FSM: next state ----------------
    // Abort outranks every other exit; an output tlast while input is still
    // running is treated like an abort.
    always_comb begin
        nxt_state = state;
        err_ld    = 1'b0;
        err_val   = ERR_OK;
        unique case (state)
            ST_IDLE:  if (start_req) nxt_state = ST_CHECK;
            ST_CHECK: nxt_state = cfg_ok ? ST_RUN : ST_DONE;
            ST_RUN: begin
                if (abort || (out_xfer && mon_tlast)) begin
                    nxt_state = ST_FLUSH;
                    err_ld    = 1'b1;
                    err_val   = ERR_ABORT;
                end else if (timeout) begin
                    nxt_state = ST_FLUSH;
                    err_ld    = 1'b1;
                    err_val   = ERR_TIMEOUT;
                end else if (in_xfer && src_tlast) begin
                    nxt_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    nxt_state = ST_FLUSH;
                    err_ld    = 1'b1;
                    err_val   = ERR_ABORT;
                end else if (out_xfer && mon_tlast) begin
                    nxt_state = ST_DONE;
                end else if (timeout) begin
                    nxt_state = ST_FLUSH;
                    err_ld    = 1'b1;
                    err_val   = ERR_TIMEOUT;
                end
            end
            ST_DONE:  nxt_state = ST_IDLE;
            ST_FLUSH: if (flush_cnt == FLUSH_LAST) nxt_state = ST_DONE;
            default:  nxt_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // frame_start fires in CHECK so the source sees it while the gate is
    // still closed; the gate opens on the following cycle.
    always_comb begin
        gate_open   = (state == ST_RUN);
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);
        enc_flush   = (state == ST_FLUSH);
        frame_start = (state == ST_CHECK) & cfg_ok;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_size_m1 <= '0;
            y_size_m1 <= '0;
            error     <= ERR_OK;
            size      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == ST_IDLE && start_req) begin
                x_size_m1 <= cfg_x_size_m1;
                y_size_m1 <= cfg_y_size_m1;
            end

            if (state == ST_CHECK) error <= cfg_ok ? ERR_OK : ERR_CFG;
            else if (err_ld)       error <= err_val;

            if (state == ST_CHECK)
                size <= '0;
            else if (active && out_xfer)
                size <= size_sum[20] ? 20'hFFFFF : size_sum[19:0];

            if (active && !(in_xfer || out_xfer)) stall_cnt <= stall_cnt + 1'b1;
            else                                  stall_cnt <= '0;

            if (state == ST_FLUSH) flush_cnt <= flush_cnt + 1'b1;
            else                   flush_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_jenc_frame_ctrl.sv
module tb_jenc_frame_ctrl;

    localparam int XW = 11;
    localparam int YW = 10;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start_req = 1'b0, abort = 1'b0;
    logic [XW-1:0] cfg_x_size_m1 = '0, x_size_m1;
    logic [YW-1:0] cfg_y_size_m1 = '0, y_size_m1;
    logic          frame_start, src_hold, enc_di_valid, enc_flush, busy, done;
    logic          src_valid = 1'b0, src_tlast = 1'b0, enc_di_hold = 1'b0;
    logic          mon_valid = 1'b0, mon_hold = 1'b0, mon_tlast = 1'b0;
    logic [4:0]    mon_bytes = '0;
    logic [1:0]    error;
    logic [19:0]   size;

    int total = 0;
    int bad   = 0;

    jenc_frame_ctrl #(
        .SENSOR_X_SIZE(1280), .SENSOR_Y_SIZE(720), .TIMEOUT_W(4), .FLUSH_CYCLES(4)
    ) dut (
        .clk(clk), .resetn(resetn), .start_req(start_req), .abort(abort),
        .cfg_x_size_m1(cfg_x_size_m1), .cfg_y_size_m1(cfg_y_size_m1),
        .x_size_m1(x_size_m1), .y_size_m1(y_size_m1), .frame_start(frame_start),
        .src_valid(src_valid), .src_tlast(src_tlast), .src_hold(src_hold),
        .enc_di_valid(enc_di_valid), .enc_di_hold(enc_di_hold),
        .mon_valid(mon_valid), .mon_hold(mon_hold), .mon_bytes(mon_bytes),
        .mon_tlast(mon_tlast), .enc_flush(enc_flush), .busy(busy), .done(done),
        .error(error), .size(size)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a frame; returns in the CHECK cycle with start_req dropped.
    task automatic start_frame(input logic [XW-1:0] xs, input logic [YW-1:0] ys);
        cfg_x_size_m1 = xs;
        cfg_y_size_m1 = ys;
        start_req     = 1'b1;
        tick();
        start_req = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        src_valid = 1'b1;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_hold", src_hold, 1);
        chk("rst_di_valid", enc_di_valid, 0);
        chk("rst_flush", enc_flush, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_size", size, 0);
        chk("rst_xsize", x_size_m1, 0);
        chk("rst_fstart", frame_start, 0);
        src_valid = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        tick();

        // ---- good 16x16 frame: 8 input beats, output 16+16+5 ----
        start_frame(11'd15, 10'd15);
        chk("t1_check_busy", busy, 1);
        chk("t1_fstart", frame_start, 1);
        chk("t1_xsize", x_size_m1, 15);
        chk("t1_ysize", y_size_m1, 15);
        tick();
        chk("t1_fstart_run", frame_start, 0);
        for (int i = 0; i < 8; i++) begin
            src_valid = 1'b1;
            src_tlast = (i == 7);
            mon_valid = (i == 2 || i == 5);
            mon_bytes = 5'd16;
            #1;
            chk("t1_di_valid", enc_di_valid, 1);
            chk("t1_src_hold", src_hold, 0);
            tick();
        end
        src_tlast = 1'b0;
        mon_valid = 1'b0;
        #1;
        chk("t1_drain_hold", src_hold, 1);
        chk("t1_drain_div", enc_di_valid, 0);
        chk("t1_drain_size", size, 32);
        chk("t1_drain_done", done, 0);
        mon_valid = 1'b1;
        mon_bytes = 5'd5;
        mon_tlast = 1'b1;
        tick();
        mon_valid = 1'b0;
        mon_tlast = 1'b0;
        src_valid = 1'b0;
        chk("t1_done", done, 1);
        chk("t1_size", size, 37);
        chk("t1_error", error, 0);
        tick();
        chk("t1_done_off", done, 0);
        chk("t1_idle", busy, 0);
        chk("t1_size_held", size, 37);

        // ---- bad config: width-1 = 16 is even ----
        start_frame(11'd16, 10'd15);
        chk("t2_fstart", frame_start, 0);
        chk("t2_hold", src_hold, 1);
        tick();
        chk("t2_done", done, 1);
        chk("t2_error", error, 1);
        chk("t2_hold2", src_hold, 1);
        tick();
        chk("t2_done_off", done, 0);
        chk("t2_err_held", error, 1);

        // ---- encoder hold 10 cycles, one transfer, then stall to timeout ----
        start_frame(11'd31, 10'd15);
        tick();
        src_valid   = 1'b1;
        enc_di_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t3_hold", src_hold, 1);
            chk("t3_div", enc_di_valid, 1);
            tick();
        end
        enc_di_hold = 1'b0;
        tick();
        src_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            chk("t3_no_flush_yet", enc_flush, 0);
            tick();
        end
        chk("t3_to_flush", enc_flush, 1);
        chk("t3_error", error, 3);
        for (int i = 0; i < 4; i++) begin
            chk("t3_flush_hi", enc_flush, 1);
            tick();
        end
        chk("t3_flush_lo", enc_flush, 0);
        chk("t3_done", done, 1);
        chk("t3_done_err", error, 3);
        tick();
        chk("t3_idle", busy, 0);

        // ---- abort ignored in CHECK; abort with tlast 5 cycles into RUN ----
        start_frame(11'd15, 10'd15);
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        src_valid = 1'b1;
        mon_valid = 1'b1;
        mon_bytes = 5'd7;
        #1;
        chk("t4_run_gate", enc_di_valid, 1);
        chk("t4_run_flush", enc_flush, 0);
        tick();
        mon_valid = 1'b0;
        repeat (3) tick();
        src_tlast = 1'b1;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        src_tlast = 1'b0;
        src_valid = 1'b0;
        chk("t4_flush", enc_flush, 1);
        chk("t4_error", error, 2);
        chk("t4_size", size, 7);
        chk("t4_hold", src_hold, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t4_flush_hi", enc_flush, 1);
            tick();
        end
        chk("t4_done", done, 1);
        chk("t4_done_err", error, 2);
        chk("t4_flush_lo", enc_flush, 0);
        // keep start_req high: next frame after exactly one IDLE cycle
        cfg_x_size_m1 = 11'd15;
        cfg_y_size_m1 = 10'd15;
        start_req     = 1'b1;
        tick();
        chk("t4_idle_gap", busy, 0);
        chk("t4_done_off", done, 0);
        tick();
        start_req = 1'b0;
        chk("t4_retrigger", frame_start, 1);
        chk("t4_size_held", size, 7);
        tick();
        chk("t4_size_clr", size, 0);
        chk("t4_err_clr", error, 0);

        // ---- byte count saturation (frame running from previous step) ----
        src_valid = 1'b1;
        src_tlast = 1'b1;
        tick();
        src_valid = 1'b0;
        src_tlast = 1'b0;
        mon_valid = 1'b1;
        mon_bytes = 5'd16;
        repeat (65535) tick();
        chk("t5_below_sat", size, 20'hFFFF0);
        chk("t5_busy", busy, 1);
        tick();
        chk("t5_sat", size, 20'hFFFFF);
        repeat (4463) tick();
        chk("t5_no_wrap", size, 20'hFFFFF);
        mon_tlast = 1'b1;
        tick();
        mon_valid = 1'b0;
        mon_tlast = 1'b0;
        chk("t5_done", done, 1);
        chk("t5_final", size, 20'hFFFFF);
        chk("t5_error", error, 0);
        tick();

        // ---- output tlast while input still running ----
        start_frame(11'd15, 10'd15);
        tick();
        mon_valid = 1'b1;
        mon_tlast = 1'b1;
        mon_bytes = 5'd3;
        tick();
        mon_valid = 1'b0;
        mon_tlast = 1'b0;
        chk("t6_flush", enc_flush, 1);
        chk("t6_error", error, 2);
        chk("t6_size", size, 3);
        repeat (4) tick();
        chk("t6_done", done, 1);
        tick();

        // ---- asynchronous reset mid-frame ----
        start_frame(11'd15, 10'd17);
        tick();
        chk("t7_running", busy, 1);
        chk("t7_ysize", y_size_m1, 17);
        #2 resetn = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_xsize", x_size_m1, 0);
        chk("t7_ysize_rst", y_size_m1, 0);
        chk("t7_hold", src_hold, 1);
        #10 resetn = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
